branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-side branch predictor and execute-side branch resolver for the 5-stage RISC-V pipeline. It is the consumer of the execute stage's branch outputs (`alu_zero`, `branch_type`, `target_pc`, `pc_with_offset`, `prev_pc`, `prev_pred`). It predicts next-PC for the fetch PC using a direct-mapped BTB with 2-bit saturating counters. It also resolves each branch or jump in execute, raising `flush` with the corrected PC on a mispredict and training the tables.

## Interface
- `ENTRIES`, 32: BTB/counter entries; power of two, ≥2. `IDX_BITS = $clog2(ENTRIES)`, `TAG_BITS = 30 - IDX_BITS`.
- `clk` in 1: pipeline clock.
- `rst` in 1: reset, **asynchronous, active-high**.
- `stall` in 1: pipeline freeze; same signal that holds the EX/MEM register.
- `fetch_pc` in 32: PC currently being fetched.
- `pred_taken` out 1: prediction for `fetch_pc`; forwarded down the pipe and returned as `prev_pred`.
- `pred_pc` out 32: next fetch PC.
- `branch_type` in 3: from execute.
  - 000 none; 001 BEQ; 010 BNE; 011 BLT/BLTU; 100 BGE/BGEU; 101 JAL; 110 JALR; 111 treated as none.
- `alu_zero` in 1: ALU result is zero.
- `prev_pc` in 32: PC of the instruction in execute.
- `prev_pred` in 1: prediction made for that instruction.
- `target_pc` in 32: ALU output, used as the JALR target.
- `pc_with_offset` in 32: `prev_pc + imm`, used as the branch/JAL target.
- `flush` out 1: mispredict; squash IF/ID and ID/EX.
- `correct_pc` out 32: fetch PC to use when `flush` is high.

## Operation
- **Indexing:**
  - index = `pc[IDX_BITS+1:2]`.
  - tag = `pc[31:IDX_BITS+2]`.
  - Each entry holds: valid, tag, target[31:0], ctr[1:0].
- **Predict (combinational):**
  - hit = valid && tag match.
  - `pred_taken` = hit && ctr[1].
  - `pred_pc` = `pred_taken` ? target : `fetch_pc`+4.
- **Predicted-target tracking:**
  - Two-stage shift register (ID, EX) carries {`pred_pc`} alongside the instruction.
  - Advances when `!stall`.
  - On `flush`, both stages load 0 (bubble).
- **Resolve:** `resolve = (branch_type ∈ 001..110) && !stall`.
- **Actual taken:**
  - BEQ: `alu_zero`.
  - BNE: `!alu_zero`.
  - BLT: `!alu_zero` (ALU computes SLT).
  - BGE: `alu_zero`.
  - JAL/JALR: 1.
- **Actual target:**
  - JALR: `target_pc & ~32'h1`.
  - All others: `pc_with_offset`.
- **Mispredict** = resolve && ((taken != `prev_pred`) || (taken && `prev_pred` && actual target != EX-stage tracked `pred_pc`)).
- **Outputs on resolve:**
  - `flush` = mispredict.
  - `correct_pc` = taken ? actual target : `prev_pc`+4.
  - When `flush`=0, `correct_pc` = `prev_pc`+4 (don't-care).
- **Update (posedge, when resolve):**
  - Hit, conditional branch: ctr saturating ±1 (max 11, min 00); target overwritten when taken.
  - Hit, JAL/JALR: ctr = 11, target = actual target.
  - Miss and taken: allocate the entry (valid=1, tag, target). ctr = 11 for jumps, 10 for branches.
  - Miss and not taken: no change.

## Timing
- Prediction is zero-latency and combinational from `fetch_pc`.
- Resolution is same-cycle: `flush` and `correct_pc` are combinational in the cycle the branch sits in execute.
- Table writes land on the following edge.
- Same-index predict and update in one cycle: predict sees the pre-update entry.
- An instruction fetched in cycle t reaches execute at t+2 when there are no stalls. Each stalled cycle adds 1.
- `stall` high: no table update, shift register held, `flush` = 0.
- Reset (async, any time, including mid-resolve):
  - All valid bits, tags, targets and the shift register clear; ctr resets to 01.
  - Resulting outputs: `pred_taken`=0, `pred_pc`=`fetch_pc`+4.
  - `flush` is driven only by inputs and is 0 while `branch_type`=000.
- Counter arithmetic saturates; no wrap. `pc+4` wraps modulo 2^32.

## Configuration
- **`BP_PERF_EN` defined:** adds outputs `perf_branches` (32) and `perf_mispredicts` (32).
  - Reset to 0.
  - `perf_branches` increments on every resolve; `perf_mispredicts` increments on every `flush`.
  - Both wrap modulo 2^32.
- **Undefined:** neither port nor counter exists. Predictor behaviour is identical.

## Test plan
- Reset, then `fetch_pc`=0x100 → `pred_taken`=0, `pred_pc`=0x104. BEQ resolved at 0x100 with `alu_zero`=1, `pc_with_offset`=0x140, `prev_pred`=0 → `flush`=1, `correct_pc`=0x140. Next cycle, `fetch_pc`=0x100 → `pred_taken`=1, `pred_pc`=0x140.
- BNE at 0x200 resolved not-taken 3 times after one taken → ctr path 10→01→00→00. Lookup at 0x200 gives `pred_taken`=0. A not-taken resolve with `prev_pred`=0 gives `flush`=0.
- JALR at 0x300, `target_pc`=0x1235 → actual target 0x1234, `flush`=1. Rerun with `prev_pred`=1 but tracked `pred_pc`=0x2000 → `flush`=1, `correct_pc`=0x1234.
- Aliasing: entry at 0x100 trained taken, then `fetch_pc`=0x100+4·`ENTRIES` → tag miss, `pred_taken`=0.
- `stall`=1 with BEQ in execute for 3 cycles → `flush`=0 and ctr unchanged. Stall drops → exactly one update.
- `rst` asserted mid-resolve → tables cleared immediately; with `BP_PERF_EN`, both counters read 0.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters for fetch-side prediction,
// plus same-cycle branch/jump resolution in execute with flush and table training.
// Optional feature macro: BP_PERF_EN adds perf_branches / perf_mispredicts counters.
// Ports:
//   clk, rst (async, active-high), stall (pipeline freeze)
//   fetch_pc -> pred_taken, pred_pc         : combinational prediction
//   branch_type, alu_zero, prev_pc, prev_pred,
//   target_pc, pc_with_offset -> flush, correct_pc : combinational resolution
//   perf_branches, perf_mispredicts         : only with BP_PERF_EN
module branch_predictor #(
    parameter int ENTRIES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_pc,
    input  logic [2:0]  branch_type,
    input  logic        alu_zero,
    input  logic [31:0] prev_pc,
    input  logic        prev_pred,
    input  logic [31:0] target_pc,
    input  logic [31:0] pc_with_offset,
    output logic        flush,
    output logic [31:0] correct_pc
`ifdef BP_PERF_EN
    ,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
`endif
);
    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS = 30 - IDX_BITS;

    logic                r_valid  [ENTRIES];
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [31:0]         r_target [ENTRIES];
    logic [1:0]          r_ctr    [ENTRIES];
    logic [31:0]         r_id_pred;
    logic [31:0]         r_ex_pred;

    logic [IDX_BITS-1:0] w_f_idx, w_u_idx;
    logic [TAG_BITS-1:0] w_f_tag, w_u_tag;
    logic                w_f_hit, w_u_hit;
    logic                w_is_jump, w_is_br, w_resolve, w_taken, w_write;
    logic [31:0]         w_act_tgt;
    logic [1:0]          w_ctr_old, w_ctr_new;

    assign w_f_idx    = fetch_pc[IDX_BITS+1:2];
    assign w_f_tag    = fetch_pc[31:IDX_BITS+2];
    assign w_f_hit    = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign pred_taken = w_f_hit && r_ctr[w_f_idx][1];
    assign pred_pc    = pred_taken ? r_target[w_f_idx] : fetch_pc + 32'd4;

    assign w_is_jump = (branch_type == 3'b101) || (branch_type == 3'b110);
    assign w_is_br   = (branch_type != 3'b000) && (branch_type <= 3'b100);
    assign w_resolve = (w_is_jump || w_is_br) && !stall;
    // BLT relies on the ALU computing SLT, so "less than" shows up as a non-zero result.
    assign w_taken   = w_is_jump
                     || (((branch_type == 3'b001) || (branch_type == 3'b100)) && alu_zero)
                     || (((branch_type == 3'b010) || (branch_type == 3'b011)) && !alu_zero);
    assign w_act_tgt = (branch_type == 3'b110) ? (target_pc & ~32'h1) : pc_with_offset;

    // A taken-and-predicted-taken branch still mispredicts if the BTB target was stale.
    assign flush      = w_resolve && ((w_taken != prev_pred)
                        || (w_taken && prev_pred && (w_act_tgt != r_ex_pred)));
    assign correct_pc = (flush && w_taken) ? w_act_tgt : prev_pc + 32'd4;

    assign w_u_idx   = prev_pc[IDX_BITS+1:2];
    assign w_u_tag   = prev_pc[31:IDX_BITS+2];
    assign w_u_hit   = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
    assign w_ctr_old = r_ctr[w_u_idx];
    assign w_ctr_new = !w_u_hit ? (w_is_jump ? 2'b11 : 2'b10)
                     : w_is_jump ? 2'b11
                     : w_taken ? ((w_ctr_old == 2'b11) ? 2'b11 : w_ctr_old + 2'd1)
                     : ((w_ctr_old == 2'b00) ? 2'b00 : w_ctr_old - 2'd1);
    // Misses that resolve not-taken leave the table alone.
    assign w_write   = w_resolve && (w_u_hit || w_taken);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (w_write) begin
            r_valid[w_u_idx] <= 1'b1;
            r_tag[w_u_idx]   <= w_u_tag;
            r_ctr[w_u_idx]   <= w_ctr_new;
            if (w_taken)
                r_target[w_u_idx] <= w_act_tgt;
        end
    end

    // Carries each instruction's predicted next PC down to execute for target checking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id_pred <= '0;
            r_ex_pred <= '0;
        end else if (flush) begin
            r_id_pred <= '0;
            r_ex_pred <= '0;
        end else if (!stall) begin
            r_id_pred <= pred_pc;
            r_ex_pred <= r_id_pred;
        end
    end

`ifdef BP_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (w_resolve)
                perf_branches <= perf_branches + 32'd1;
            if (flush)
                perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed and random checks of branch_predictor against a table model.
module tb_branch_predictor;
    localparam int ENTRIES = 32;

    logic        clk = 1'b0;
    logic        rst, stall, alu_zero, prev_pred;
    logic [31:0] fetch_pc, prev_pc, target_pc, pc_with_offset;
    logic [2:0]  branch_type;
    logic        pred_taken, flush;
    logic [31:0] pred_pc, correct_pc;
`ifdef BP_PERF_EN
    logic [31:0] perf_branches, perf_mispredicts;
`endif

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk(clk), .rst(rst), .stall(stall), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_pc(pred_pc), .branch_type(branch_type),
        .alu_zero(alu_zero), .prev_pc(prev_pc), .prev_pred(prev_pred),
        .target_pc(target_pc), .pc_with_offset(pc_with_offset),
        .flush(flush), .correct_pc(correct_pc)
`ifdef BP_PERF_EN
        , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs = 0;

    bit          m_v   [ENTRIES];
    int unsigned m_tag [ENTRIES];
    int unsigned m_tgt [ENTRIES];
    int          m_ctr [ENTRIES];
    int unsigned m_id, m_ex, m_br, m_mis;

    bit          s_res, s_taken, s_fl, s_jump, s_st;
    int unsigned s_pp, s_tgt, s_pc;

    task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tg, obs, exp);
        end
    endtask

    function automatic int idx_of(input int unsigned pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic int unsigned tag_of(input int unsigned pc);
        return pc / (4 * ENTRIES);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_id = 0; m_ex = 0; m_br = 0; m_mis = 0;
    endtask

    task automatic step(input logic [2:0] bt, input logic az, input logic [31:0] fpc,
                        input logic [31:0] pc, input logic pp, input logic [31:0] tpc,
                        input logic [31:0] pwo, input logic st);
        int  i;
        bit  hit, pt;
        int unsigned cp;
        branch_type = bt; alu_zero = az; fetch_pc = fpc; prev_pc = pc;
        prev_pred = pp; target_pc = tpc; pc_with_offset = pwo; stall = st;
        #1;
        i = idx_of(fpc);
        hit = m_v[i] && m_tag[i] == tag_of(fpc);
        pt = hit && m_ctr[i] >= 2;
        s_pp = pt ? m_tgt[i] : fpc + 4;
        s_jump = (bt == 5) || (bt == 6);
        s_res = (bt inside {[1:6]}) && !st;
        case (bt)
            3'd1, 3'd4: s_taken = az;
            3'd2, 3'd3: s_taken = !az;
            3'd5, 3'd6: s_taken = 1;
            default:    s_taken = 0;
        endcase
        s_tgt = (bt == 6) ? (tpc & 32'hFFFF_FFFE) : pwo;
        s_fl = s_res && ((s_taken != pp) || (s_taken && pp && s_tgt != m_ex));
        s_pc = pc; s_st = st;
        cp = s_taken ? s_tgt : pc + 4;
        chk("pred_taken", {31'b0, pred_taken}, {31'b0, pt});
        chk("pred_pc", pred_pc, s_pp);
        chk("flush", {31'b0, flush}, {31'b0, s_fl});
        if (s_fl) chk("correct_pc", correct_pc, cp);
`ifdef BP_PERF_EN
        chk("perf_branches", perf_branches, m_br);
        chk("perf_mispredicts", perf_mispredicts, m_mis);
`endif
    endtask

    task automatic tick();
        int u;
        bit uh;
        @(posedge clk);
        if (rst) model_reset();
        else begin
            if (s_res) begin
                m_br++;
                if (s_fl) m_mis++;
                u = idx_of(s_pc);
                uh = m_v[u] && m_tag[u] == tag_of(s_pc);
                if (uh) begin
                    if (s_jump) m_ctr[u] = 3;
                    else m_ctr[u] = s_taken ? ((m_ctr[u] < 3) ? m_ctr[u] + 1 : 3)
                                            : ((m_ctr[u] > 0) ? m_ctr[u] - 1 : 0);
                    if (s_taken) m_tgt[u] = s_tgt;
                end else if (s_taken) begin
                    m_v[u] = 1; m_tag[u] = tag_of(s_pc); m_tgt[u] = s_tgt;
                    m_ctr[u] = s_jump ? 3 : 2;
                end
            end
            if (!s_st) begin
                if (s_fl) begin
                    m_id = 0; m_ex = 0;
                end else begin
                    m_ex = m_id; m_id = s_pp;
                end
            end
        end
        @(negedge clk);
    endtask

    int unsigned pcs  [6] = '{32'h100, 32'h200, 32'h300, 32'h180, 32'h204, 32'hFFFF_FFFC};
    int unsigned tgts [4] = '{32'h140, 32'h280, 32'h1000, 32'h2000};

    initial begin
        rst = 1; stall = 0; fetch_pc = 0; prev_pc = 0; prev_pred = 0; alu_zero = 0;
        target_pc = 0; pc_with_offset = 0; branch_type = 0;
        model_reset();
        s_res = 0; s_fl = 0; s_st = 1;
        @(negedge clk); @(negedge clk);
        rst = 0;

        step(0, 0, 32'h100, 0, 0, 0, 0, 0);
        chk("reset pred_taken", {31'b0, pred_taken}, 32'd0);
        chk("reset pred_pc", pred_pc, 32'h104);
        tick();
        step(1, 1, 32'h100, 32'h100, 0, 0, 32'h140, 0);
        chk("beq flush", {31'b0, flush}, 32'd1);
        chk("beq correct_pc", correct_pc, 32'h140);
        tick();
        step(0, 0, 32'h100, 0, 0, 0, 0, 0);
        chk("trained pred_pc", pred_pc, 32'h140);
        tick();
        step(0, 0, 32'h100 + 4 * ENTRIES, 0, 0, 0, 0, 0);
        chk("alias pred_taken", {31'b0, pred_taken}, 32'd0);
        tick();

        step(2, 0, 32'h200, 32'h200, 0, 0, 32'h280, 0);
        tick();
        step(2, 1, 32'h200, 32'h200, 1, 0, 32'h280, 0);
        tick();
        step(2, 1, 32'h200, 32'h200, 0, 0, 32'h280, 0);
        tick();
        step(2, 1, 32'h200, 32'h200, 0, 0, 32'h280, 0);
        chk("bne nt flush", {31'b0, flush}, 32'd0);
        tick();
        step(0, 0, 32'h200, 0, 0, 0, 0, 0);
        chk("bne pred_taken", {31'b0, pred_taken}, 32'd0);
        tick();

        step(6, 0, 32'h0, 32'h300, 0, 32'h1235, 32'h999, 0);
        chk("jalr correct_pc", correct_pc, 32'h1234);
        tick();
        step(0, 0, 32'h1FFC, 0, 0, 0, 0, 0);
        tick();
        step(0, 0, 32'h104, 0, 0, 0, 0, 0);
        tick();
        step(6, 0, 32'h0, 32'h300, 1, 32'h1235, 32'h999, 0);
        chk("jalr stale flush", {31'b0, flush}, 32'd1);
        chk("jalr stale correct_pc", correct_pc, 32'h1234);
        tick();

        for (int k = 0; k < 3; k++) begin
            step(1, 1, 32'h0, 32'h100, 0, 0, 32'h140, 1);
            chk("stall flush", {31'b0, flush}, 32'd0);
            tick();
        end
        step(1, 1, 32'h0, 32'h100, 0, 0, 32'h140, 0);
        tick();
        step(0, 0, 32'h100, 0, 0, 0, 0, 0);
        chk("post-stall pred_taken", {31'b0, pred_taken}, 32'd1);
        tick();

        step(1, 1, 32'h100, 32'h100, 0, 0, 32'h140, 0);
        rst = 1;
        #1;
        model_reset();
        chk("rst pred_taken", {31'b0, pred_taken}, 32'd0);
        chk("rst pred_pc", pred_pc, 32'h104);
`ifdef BP_PERF_EN
        chk("rst perf_branches", perf_branches, 32'd0);
        chk("rst perf_mispredicts", perf_mispredicts, 32'd0);
`endif
        tick();
        rst = 0;

        for (int k = 0; k < 400; k++) begin
            step(3'($urandom_range(0, 7)), 1'($urandom), pcs[$urandom_range(0, 5)],
                 pcs[$urandom_range(0, 5)], 1'($urandom), $urandom,
                 tgts[$urandom_range(0, 3)], $urandom_range(0, 4) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
